// File: rtl/vsi_ctrl_unit.sv
// vsi_ctrl_unit: RVV instruction buffer, decode/legality check and READ/EXEC/WB sequencer.
// Define VSI_INSN_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module vsi_ctrl_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        vsi_clk,
    input  logic        vsi_rst,
    input  logic        vsi_insn_valid,
    output logic        vsi_insn_ready,
    input  logic [31:0] vsi_insn,
    input  logic        cfg_lmul,
    input  logic        cfg_sew,
    output logic        exec_en,
    output logic        is_vxor,
    output logic        is_vmacc,
    output logic        is_vredsum,
    output logic        is_vslideup,
    output logic        is_vrgather,
    output logic        vsi_lmul,
    output logic        vsi_sew,
    output logic [4:0]  vd_addr,
    output logic [4:0]  vs1_addr,
    output logic [4:0]  vs2_addr,
    output logic [4:0]  uimm,
    output logic        wb_en,
    output logic        vsi_done,
    output logic        vsi_illegal
);
    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB} state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    state_t      state;
    logic [33:0] entry;
    logic [33:0] head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign entry = {vsi_insn, cfg_lmul, cfg_sew};
    assign push  = vsi_insn_valid & vsi_insn_ready;
    assign pop   = (state == IDLE) & ~empty;

`ifdef VSI_INSN_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full           = count == (AW + 1)'(FIFO_DEPTH);
    assign empty          = count == '0;
    assign head           = mem[rd_ptr];
    assign vsi_insn_ready = ~full;

    always_ff @(posedge vsi_clk) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
`else
    logic [33:0] hold;
    logic        held;

    assign full           = held;
    assign empty          = ~held;
    assign head           = hold;
    assign vsi_insn_ready = ~held & (state == IDLE);

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            hold <= '0;
            held <= 1'b0;
        end else if (push) begin
            hold <= entry;
            held <= 1'b1;
        end else if (pop) begin
            held <= 1'b0;
        end
    end
`endif

    // Decode runs on the buffer head so the illegal pulse lands in the DECODE cycle.
    logic [31:0] h_insn;
    logic [5:0]  h_f6;
    logic [2:0]  h_f3;
    logic [4:0]  h_vd;
    logic [4:0]  h_vs1;
    logic [4:0]  h_vs2;
    logic        h_lmul;
    logic [4:0]  d_op;
    logic        d_legal;
    logic        grp_bad;
    logic        ovl_bad;

    assign h_insn = head[33:2];
    assign h_lmul = head[1];
    assign h_f6   = h_insn[31:26];
    assign h_f3   = h_insn[14:12];
    assign h_vd   = h_insn[11:7];
    assign h_vs1  = h_insn[19:15];
    assign h_vs2  = h_insn[24:20];
    assign d_op   = {h_f3 == 3'b000 && h_f6 == 6'b001011,
                     h_f3 == 3'b010 && h_f6 == 6'b101101,
                     h_f3 == 3'b010 && h_f6 == 6'b000000,
                     h_f3 == 3'b011 && h_f6 == 6'b001110,
                     h_f3 == 3'b000 && h_f6 == 6'b001100};
    assign grp_bad = h_lmul & ((h_vd[1:0] != 2'b00) | (h_vs2[1:0] != 2'b00) |
                               (~d_op[2] & (h_vs1[1:0] != 2'b00)));
    assign ovl_bad = (d_op[1] | d_op[0]) & (h_vd == h_vs2);
    assign d_legal = (h_insn[6:0] == 7'b1010111) & h_insn[25] & (d_op != '0) & ~grp_bad & ~ovl_bad;

    logic [4:0] op;
    logic [4:0] w_op;
    logic       w_legal;
    logic [4:0] w_vd;
    logic [4:0] w_vs1;
    logic [4:0] w_vs2;
    logic       w_lmul;
    logic       w_sew;
    logic [1:0] cnt;
    logic [1:0] last;

    assign {is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather} = op;
    assign uimm = vs1_addr;
    assign last = (is_vredsum & vsi_lmul) ? 2'd3 : 2'd0;

    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            vd_addr     <= '0;
            vs1_addr    <= '0;
            vs2_addr    <= '0;
            vsi_lmul    <= 1'b0;
            vsi_sew     <= 1'b0;
            exec_en     <= 1'b0;
            wb_en       <= 1'b0;
            vsi_done    <= 1'b0;
            vsi_illegal <= 1'b0;
            w_op        <= '0;
            w_legal     <= 1'b0;
            w_vd        <= '0;
            w_vs1       <= '0;
            w_vs2       <= '0;
            w_lmul      <= 1'b0;
            w_sew       <= 1'b0;
        end else begin
            vsi_illegal <= 1'b0;
            wb_en       <= 1'b0;
            vsi_done    <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    w_op        <= d_op;
                    w_legal     <= d_legal;
                    w_vd        <= h_vd;
                    w_vs1       <= h_vs1;
                    w_vs2       <= h_vs2;
                    w_lmul      <= h_lmul;
                    w_sew       <= head[0];
                    vsi_illegal <= ~d_legal;
                    state       <= DECODE;
                end
                DECODE: begin
                    if (w_legal) begin
                        op       <= w_op;
                        vd_addr  <= w_vd;
                        vs1_addr <= w_vs1;
                        vs2_addr <= w_vs2;
                        vsi_lmul <= w_lmul;
                        vsi_sew  <= w_sew;
                    end
                    state <= w_legal ? READ : IDLE;
                end
                READ: begin
                    exec_en <= 1'b1;
                    cnt     <= '0;
                    state   <= EXEC;
                end
                EXEC: if (cnt == last) begin
                    exec_en  <= 1'b0;
                    wb_en    <= 1'b1;
                    vsi_done <= 1'b1;
                    state    <= WB;
                end else begin
                    cnt <= cnt + 2'd1;
                end
                WB: begin
                    op       <= '0;
                    vd_addr  <= '0;
                    vs1_addr <= '0;
                    vs2_addr <= '0;
                    vsi_lmul <= 1'b0;
                    vsi_sew  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vsi_ctrl_unit.sv
// tb_vsi_ctrl_unit: directed checks of vsi_ctrl_unit latency, legality, reset flush and buffering.
module tb_vsi_ctrl_unit;
    logic        vsi_clk = 1'b0;
    logic        vsi_rst = 1'b1;
    logic        vsi_insn_valid = 1'b0;
    logic        vsi_insn_ready;
    logic [31:0] vsi_insn = '0;
    logic        cfg_lmul = 1'b0;
    logic        cfg_sew = 1'b0;
    logic        exec_en, is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather;
    logic        vsi_lmul, vsi_sew, wb_en, vsi_done, vsi_illegal;
    logic [4:0]  vd_addr, vs1_addr, vs2_addr, uimm;

    int errors = 0;
    int checks = 0;

    logic [15:0] t_exec, t_wb, t_done, t_ill, t_rdy;
    logic [4:0]  t_op [16];
    logic [4:0]  t_vd [16];
    logic [4:0]  t_vs1 [16];
    logic [4:0]  t_vs2 [16];
    logic [4:0]  t_uimm [16];
    logic        t_lmul [16];
    logic        t_sew [16];

    vsi_ctrl_unit #(.FIFO_DEPTH(2)) dut (
        .vsi_clk(vsi_clk), .vsi_rst(vsi_rst), .vsi_insn_valid(vsi_insn_valid),
        .vsi_insn_ready(vsi_insn_ready), .vsi_insn(vsi_insn), .cfg_lmul(cfg_lmul), .cfg_sew(cfg_sew),
        .exec_en(exec_en), .is_vxor(is_vxor), .is_vmacc(is_vmacc), .is_vredsum(is_vredsum),
        .is_vslideup(is_vslideup), .is_vrgather(is_vrgather), .vsi_lmul(vsi_lmul), .vsi_sew(vsi_sew),
        .vd_addr(vd_addr), .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .uimm(uimm),
        .wb_en(wb_en), .vsi_done(vsi_done), .vsi_illegal(vsi_illegal)
    );

    always #5 vsi_clk = ~vsi_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                        input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'b1010111};
    endfunction

    function automatic logic [31:0] outs();
        return {exec_en, is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather, vsi_lmul, vsi_sew,
                vd_addr, vs1_addr, vs2_addr, uimm, wb_en, vsi_done, vsi_illegal, vsi_insn_ready};
    endfunction

    // Drives one instruction for exactly one cycle; the following cycle is T+1.
    task automatic send(input logic [31:0] insn, input logic lmul, input logic sew);
        @(negedge vsi_clk);
        chk("ready_before_send", 32'(vsi_insn_ready), 32'd1);
        vsi_insn = insn;
        cfg_lmul = lmul;
        cfg_sew = sew;
        vsi_insn_valid = 1'b1;
        @(posedge vsi_clk);
        #1 vsi_insn_valid = 1'b0;
    endtask

    // Captures cycles T+1 .. T+n; index i holds cycle T+1+i.
    task automatic run(input int n);
        t_exec = '0; t_wb = '0; t_done = '0; t_ill = '0; t_rdy = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge vsi_clk);
            t_exec[i] = exec_en;
            t_wb[i] = wb_en;
            t_done[i] = vsi_done;
            t_ill[i] = vsi_illegal;
            t_rdy[i] = vsi_insn_ready;
            t_op[i] = {is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather};
            t_vd[i] = vd_addr;
            t_vs1[i] = vs1_addr;
            t_vs2[i] = vs2_addr;
            t_uimm[i] = uimm;
            t_lmul[i] = vsi_lmul;
            t_sew[i] = vsi_sew;
        end
    endtask

    task automatic expect_illegal(input string tag, input logic [31:0] insn, input logic lmul);
        send(insn, lmul, 1'b0);
        run(6);
        chk({tag, "_ill"}, 32'(t_ill), 32'h02);
        chk({tag, "_exec"}, 32'(t_exec), 32'h0);
        chk({tag, "_wb"}, 32'(t_wb), 32'h0);
        chk({tag, "_done"}, 32'(t_done), 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge vsi_clk);
        #1 vsi_rst = 1'b0;
        @(negedge vsi_clk);
        chk("reset_outputs", outs(), 32'h1);

        // vxor.vv vd=3 vs1=1 vs2=2, lmul=0
        send(enc(6'b001011, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0);
        run(8);
        chk("vxor_exec", 32'(t_exec), 32'h08);
        chk("vxor_wb", 32'(t_wb), 32'h10);
        chk("vxor_done", 32'(t_done), 32'h10);
        chk("vxor_ill", 32'(t_ill), 32'h0);
        chk("vxor_op_decode", 32'(t_op[1]), 32'h0);
        chk("vxor_op_read", 32'(t_op[2]), 32'h10);
        chk("vxor_op_wb", 32'(t_op[4]), 32'h10);
        chk("vxor_op_idle", 32'(t_op[5]), 32'h0);
        chk("vxor_vd", 32'(t_vd[2]), 32'd3);
        chk("vxor_vs1", 32'(t_vs1[2]), 32'd1);
        chk("vxor_vs2", 32'(t_vs2[2]), 32'd2);
`ifdef VSI_INSN_FIFO_EN
        chk("vxor_ready", 32'(t_rdy[7:0]), 32'hFF);
`else
        chk("vxor_ready", 32'(t_rdy[7:0]), 32'hE0);
`endif

        // vredsum.vs lmul=1 vs2=8 vs1=5 vd=4, sew=1
        send(enc(6'b000000, 1'b1, 5'd8, 5'd5, 3'b010, 5'd4), 1'b1, 1'b1);
        run(12);
        chk("vred_exec", 32'(t_exec), 32'h078);
        chk("vred_done", 32'(t_done), 32'h080);
        chk("vred_wb", 32'(t_wb), 32'h080);
        chk("vred_op", 32'(t_op[2]), 32'h04);
        chk("vred_lmul", 32'(t_lmul[7]), 32'd1);
        chk("vred_sew", 32'(t_sew[3]), 32'd1);
        chk("vred_vs1", 32'(t_vs1[5]), 32'd5);

        // vslideup.vi vd=4 vs2=8 uimm=3, lmul=0
        send(enc(6'b001110, 1'b1, 5'd8, 5'd3, 3'b011, 5'd4), 1'b0, 1'b0);
        run(7);
        chk("vslide_done", 32'(t_done), 32'h10);
        chk("vslide_op", 32'(t_op[3]), 32'h02);
        chk("vslide_uimm", 32'(t_uimm[2]), 32'd3);

        // vmacc lmul=1 with aligned groups vd=4 vs1=8 vs2=12
        send(enc(6'b101101, 1'b1, 5'd12, 5'd8, 3'b010, 5'd4), 1'b1, 1'b0);
        run(7);
        chk("vmacc_done", 32'(t_done), 32'h10);
        chk("vmacc_exec", 32'(t_exec), 32'h08);
        chk("vmacc_op", 32'(t_op[2]), 32'h08);

        expect_illegal("vmacc_vm0", enc(6'b101101, 1'b0, 5'd8, 5'd4, 3'b010, 5'd0), 1'b0);
        expect_illegal("vslide_ovl", enc(6'b001110, 1'b1, 5'd4, 5'd0, 3'b011, 5'd4), 1'b0);
        expect_illegal("vxor_align", enc(6'b001011, 1'b1, 5'd4, 5'd0, 3'b000, 5'd6), 1'b1);
        expect_illegal("vrg_ovl", enc(6'b001100, 1'b1, 5'd4, 5'd8, 3'b000, 5'd4), 1'b1);
        expect_illegal("bad_funct", enc(6'b111111, 1'b1, 5'd4, 5'd8, 3'b000, 5'd0), 1'b0);

        // Reset during EXEC of a 4-cycle vredsum
        send(enc(6'b000000, 1'b1, 5'd8, 5'd5, 3'b010, 5'd4), 1'b1, 1'b0);
        run(4);
        @(negedge vsi_clk);
        chk("rst_in_exec", 32'(exec_en), 32'd1);
        vsi_rst = 1'b1;
        @(posedge vsi_clk);
        #1 vsi_rst = 1'b0;
        @(negedge vsi_clk);
        chk("rst_flush_outputs", outs(), 32'h1);
        run(8);
        chk("rst_no_done", 32'(t_done), 32'h0);
        chk("rst_no_exec", 32'(t_exec), 32'h0);
        send(enc(6'b001011, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0);
        run(7);
        chk("post_rst_done", 32'(t_done), 32'h10);

`ifdef VSI_INSN_FIFO_EN
        // Three back-to-back vxor with vd=1,2,3 into a 2-entry buffer
        @(negedge vsi_clk);
        vsi_insn = enc(6'b001011, 1'b1, 5'd0, 5'd0, 3'b000, 5'd1);
        cfg_lmul = 1'b0;
        vsi_insn_valid = 1'b1;
        @(posedge vsi_clk);
        #1 vsi_insn = enc(6'b001011, 1'b1, 5'd0, 5'd0, 3'b000, 5'd2);
        @(negedge vsi_clk);
        chk("fifo_ready_b", 32'(vsi_insn_ready), 32'd1);
        @(posedge vsi_clk);
        #1 vsi_insn = enc(6'b001011, 1'b1, 5'd0, 5'd0, 3'b000, 5'd3);
        @(negedge vsi_clk);
        chk("fifo_ready_c", 32'(vsi_insn_ready), 32'd1);
        @(posedge vsi_clk);
        #1 vsi_insn_valid = 1'b0;
        run(16);
        chk("fifo_ready", 32'(t_rdy), 32'hFFF0);
        chk("fifo_done", 32'(t_done), 32'h1084);
        chk("fifo_order", {17'd0, t_vd[2], t_vd[7], t_vd[12]}, {17'd0, 5'd1, 5'd2, 5'd3});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vsi_ctrl_unit.md
# vsi_ctrl_unit

Instruction-issue control stage that sits directly upstream of the vector datapath. It accepts 32-bit RVV instructions over a valid/ready handshake and buffers them. It decodes and checks each instruction, then sequences it through read, execute and write-back phases. It drives the datapath's operation selects, operand IDs, config and `exec_en`, and reports completion or an illegal instruction per issued instruction.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2; used only with `VSI_INSN_FIFO_EN`.

Ports:
- `vsi_clk`  in  1  single clock; all logic is on the rising edge.
- `vsi_rst`  in  1  synchronous, active-high reset.
- `vsi_insn_valid`  in  1  instruction offered.
- `vsi_insn_ready`  out  1  block can accept the instruction.
- `vsi_insn`  in  32  RVV instruction word.
- `cfg_lmul`  in  1  0 = 1 register per operand; 1 = 4-register group. Sampled on accept.
- `cfg_sew`  in  1  0 = int8; 1 = int32. Sampled on accept.
- `exec_en`  out  1  datapath execute enable.
- `is_vxor`, `is_vmacc`, `is_vredsum`, `is_vslideup`, `is_vrgather`  out  1 each  one-hot operation select.
- `vsi_lmul`, `vsi_sew`  out  1 each  latched config of the in-flight instruction.
- `vd_addr`, `vs1_addr`, `vs2_addr`, `uimm`  out  5 each  operand IDs.
- `wb_en`  out  1  register-file write enable (gates write strobes).
- `vsi_done`  out  1  one-cycle pulse at write-back of a legal instruction.
- `vsi_illegal`  out  1  one-cycle pulse when an instruction is rejected.

## Operation
- Accept: a transfer happens on an edge where `vsi_insn_valid & vsi_insn_ready` is high. The block stores {insn, cfg_lmul, cfg_sew}.
- Decode checks opcode[6:0]=1010111 and vm (bit 25)=1. The remaining fields decode as follows:
  - funct3 000 with funct6 001011 → vxor.
  - funct3 000 with funct6 001100 → vrgather.
  - funct3 010 with funct6 101101 → vmacc.
  - funct3 010 with funct6 000000 → vredsum.
  - funct3 011 with funct6 001110 → vslideup.
  - Anything else is illegal.
- Field mapping: vd=[11:7], vs1 and uimm=[19:15], vs2=[24:20].
- Legality checks with lmul=1:
  - vd and vs2 must be multiples of 4.
  - vs1 must also be a multiple of 4, except for vredsum.
  - vslideup or vrgather with vd==vs2 is illegal, in either lmul.
- FSM states:
  - IDLE: if the buffer is non-empty, pop the head into the working register and go to DECODE.
  - DECODE: if the instruction is illegal, pulse `vsi_illegal` and go to IDLE. Otherwise register the selects, IDs and config, then go to READ.
  - READ: operand IDs are stable. Go to EXEC.
  - EXEC: `exec_en`=1. The counter loads 0 on entry. Stay in EXEC until count = N-1, then go to WB.
    - N=4 for vredsum with lmul=1.
    - N=1 otherwise.
  - WB: `wb_en`=1 and `vsi_done`=1 for one cycle, then go to IDLE.
- `is_*` and the operand IDs hold their values from READ through WB. They are 0 in IDLE and DECODE.
- The buffer is written at the tail and popped only in IDLE.

## Timing
- Reset value of every output is 0, except `vsi_insn_ready`, which is 1.
- Reset flushes the buffer, forces IDLE and clears the EXEC counter. The in-flight instruction is discarded and no done/illegal pulse is produced for it.
- Latency with an empty buffer and the FSM in IDLE, accept edge at cycle T:
  - T+1: IDLE pop.
  - T+2: DECODE.
  - T+3: READ.
  - T+4 .. T+3+N: EXEC.
  - T+4+N: `vsi_done`.
  - An illegal instruction pulses `vsi_illegal` in cycle T+2.
- Back-to-back throughput: one instruction per 4+N cycles, because IDLE re-enters for one cycle between instructions.
- Handshake: `vsi_insn_ready = !full`. Push and pop in the same cycle are allowed when the buffer is neither full nor empty. A full buffer is never overwritten. Pointers wrap modulo `FIFO_DEPTH`.
- `vsi_done` and `vsi_illegal` are never high in the same cycle.

## Configuration
- `VSI_INSN_FIFO_EN` defined: the `FIFO_DEPTH`-entry buffer is present. The block accepts new instructions while one is in flight.
- `VSI_INSN_FIFO_EN` not defined: the buffer is a single holding register.
  - `vsi_insn_ready` = 1 only when the register is empty and the FSM is in IDLE.
  - Latency is the same as with the buffer; at most one instruction is held in the block at a time.

## Test plan
- vxor.vv with vd=3, vs1=1, vs2=2, lmul=0, accepted at T. Required:
  - `is_vxor` and `vd_addr`=3 from T+3.
  - `exec_en` high only in T+4.
  - `wb_en` and `vsi_done` high only in T+5.
- vredsum.vs with lmul=1, vs2=8, vs1=5. Required: `exec_en` high for 4 cycles (T+4..T+7) and `vsi_done` at T+8.
- vmacc with vm=0, then vslideup.vi with vd=vs2=4, then vxor with lmul=1 and vd=6. Required: each pulses `vsi_illegal` in its DECODE cycle with no `exec_en` or `wb_en`.
- FIFO build: present 3 back-to-back legal instructions with `FIFO_DEPTH`=2. Required:
  - `vsi_insn_ready` drops while the buffer is full.
  - All three complete in order, 5 cycles apart, with N=1.
- Reset asserted during EXEC. Required:
  - The next cycle has all outputs at 0 and `vsi_insn_ready`=1.
  - No `vsi_done` is produced for the flushed instruction.
  - A following instruction completes with normal latency.
